// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: issues sequential word fetches, buffers {pc, instr}
// in an in-order prefetch FIFO for decode, and flushes/restarts on an EX redirect.
module fetch_prefetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            if_ready,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0]     DEPTH_W    = (CW+1)'(DEPTH);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] fifo_pc    [DEPTH];
   logic [XLEN-1:0] fifo_instr [DEPTH];
   logic [XLEN-1:0] pc_q       [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr, pcq_rd, pcq_wr;
   logic [CW-1:0]   count, inflight, drop;
   logic [XLEN-1:0] hold_pc, hold_instr;
   logic [CW:0]     credits_used;
   logic            accept, rsp_ok, rsp_keep, pop;

   assign credits_used   = {1'b0, count} + {1'b0, inflight};
   assign imem_req_valid = rst && !redirect_valid && (credits_used < DEPTH_W);
   assign imem_req_addr  = fetch_pc;

   assign accept   = imem_req_valid && imem_req_ready;
   assign rsp_ok   = imem_rsp_valid && (inflight != '0);
   assign rsp_keep = rsp_ok && !redirect_valid && (drop == '0);
   assign pop      = !redirect_valid && (count != '0) && if_ready;

   // Empty FIFO shows the last presented head rather than a stale slot.
   assign if_valid = (count != '0);
   assign if_pc    = if_valid ? fifo_pc[rd_ptr]    : hold_pc;
   assign if_instr = if_valid ? fifo_instr[rd_ptr] : hold_instr;

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc   <= RESET_PC & ALIGN_MASK;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         pcq_rd     <= '0;
         pcq_wr     <= '0;
         count      <= '0;
         inflight   <= '0;
         drop       <= '0;
         hold_pc    <= '0;
         hold_instr <= '0;
      end else begin
         inflight <= inflight + CW'(accept) - CW'(rsp_ok);
         if (accept) pcq_wr <= pcq_wr + PW'(1);
         if (rsp_ok) pcq_rd <= pcq_rd + PW'(1);
         if (count != '0) begin
            hold_pc    <= fifo_pc[rd_ptr];
            hold_instr <= fifo_instr[rd_ptr];
         end
         if (redirect_valid) begin
            // Everything still in flight becomes stale; a same-cycle response is discarded here.
            fetch_pc <= redirect_pc & ALIGN_MASK;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            drop     <= inflight - CW'(rsp_ok);
         end else begin
            if (accept) fetch_pc <= fetch_pc + XLEN'(4);
            count <= count + CW'(rsp_keep) - CW'(pop);
            if (rsp_keep) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (rsp_ok && (drop != '0)) drop <= drop - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) pc_q[pcq_wr] <= fetch_pc;
      if (rsp_keep) begin
         fifo_pc[wr_ptr]    <= pc_q[pcq_rd];
         fifo_instr[wr_ptr] <= imem_rsp_data;
      end
   end

   rsp_without_request: assert property (@(posedge clk) disable iff (!rst)
      imem_rsp_valid |-> (inflight != '0));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an in-order, fixed-latency memory responder.
module tb_fetch_prefetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_ready;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc    = 0;
   int unsigned lat    = 1;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } req_t;
   req_t        mem_q[$];
   logic [31:0] acc_log[$];

   fetch_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_ready(if_ready), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Instruction word for an address: addr ^ 0xDEAD0000.
   function automatic logic [31:0] ins(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   // Memory: an accept seen at the negedge of cycle k responds at the negedge of cycle k+lat.
   always @(negedge clk) begin
      if (!rst) begin
         mem_q.delete();
         imem_rsp_valid = 1'b0;
      end else begin
         imem_rsp_valid = 1'b0;
         if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ins(mem_q[0].addr);
            void'(mem_q.pop_front());
         end
         if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
            acc_log.push_back(imem_req_addr);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; imem_req_ready = 1'b1; imem_rsp_data = '0; imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1; lat = 1;
      repeat (3) tick();
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_if_valid",  32'(if_valid), 32'd0);
      chk("rst_if_pc",     if_pc, 32'h0);
      chk("rst_if_instr",  if_instr, 32'h0);

      // Streaming, latency 1, decode always ready
      acc_log.delete();
      rst = 1'b1; #1;
      chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
      chk("t1_addr0", imem_req_addr, 32'h0);
      chk("t1_a0_if_valid", 32'(if_valid), 32'd0);
      tick();
      chk("t1_addr1", imem_req_addr, 32'h4);
      chk("t1_a1_if_valid", 32'(if_valid), 32'd0);
      tick();
      chk("t1_a2_if_valid", 32'(if_valid), 32'd1);
      chk("t1_pc0", if_pc, 32'h0);
      chk("t1_instr0", if_instr, 32'hDEAD_0000);
      tick();
      chk("t1_pc1", if_pc, 32'h4);
      chk("t1_instr1", if_instr, 32'hDEAD_0004);
      tick();
      chk("t1_pc2", if_pc, 32'h8);
      chk("t1_instr2", if_instr, 32'hDEAD_0008);

      // Back-pressure: FIFO fills, requests stop at 4 credits
      rst = 1'b0; if_ready = 1'b0; tick(); tick();
      acc_log.delete();
      rst = 1'b1;
      repeat (4) tick();
      chk("t2_stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("t2_accepts", 32'(acc_log.size()), 32'd4);
      chk("t2_last_addr", acc_log[3], 32'hC);
      chk("t2_head_pc", if_pc, 32'h0);
      tick();
      chk("t2_full_req_valid", 32'(imem_req_valid), 32'd0);
      chk("t2_full_if_valid", 32'(if_valid), 32'd1);
      if_ready = 1'b1;
      tick();
      if_ready = 1'b0; #1;
      chk("t2_resume_valid", 32'(imem_req_valid), 32'd1);
      chk("t2_resume_addr", imem_req_addr, 32'h10);
      chk("t2_head_after_pop", if_pc, 32'h4);
      tick();
      chk("t2_refull_req_valid", 32'(imem_req_valid), 32'd0);
      chk("t2_accepts_after", 32'(acc_log.size()), 32'd5);

      // Latency 3, redirect with 3 in flight (oldest response lands in the redirect cycle)
      rst = 1'b0; if_ready = 1'b1; lat = 3; tick(); tick();
      acc_log.delete();
      rst = 1'b1;
      repeat (3) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
      chk("t3_redir_req_valid", 32'(imem_req_valid), 32'd0);
      chk("t3_redir_if_valid", 32'(if_valid), 32'd0);
      tick();
      redirect_valid = 1'b0; #1;
      chk("t3_new_addr", imem_req_addr, 32'h100);
      chk("t3_new_req_valid", 32'(imem_req_valid), 32'd1);
      chk("t3_c4_if_valid", 32'(if_valid), 32'd0);
      tick();
      chk("t3_c5_if_valid", 32'(if_valid), 32'd0);
      tick();
      chk("t3_c6_if_valid", 32'(if_valid), 32'd0);
      tick();
      chk("t3_c7_if_valid", 32'(if_valid), 32'd0);
      tick();
      chk("t3_first_valid", 32'(if_valid), 32'd1);
      chk("t3_first_pc", if_pc, 32'h100);
      chk("t3_first_instr", if_instr, 32'hDEAD_0100);
      chk("t3_log_redirect", acc_log[3], 32'h100);

      // Redirect + response + pop in one cycle with count=2, inflight=2
      rst = 1'b0; if_ready = 1'b0; lat = 2; tick(); tick();
      rst = 1'b1;
      repeat (4) tick();
      chk("t4_pre_if_valid", 32'(if_valid), 32'd1);
      chk("t4_pre_req_valid", 32'(imem_req_valid), 32'd0);
      redirect_valid = 1'b1; redirect_pc = 32'h202; if_ready = 1'b1; #1;
      chk("t4_redir_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
      redirect_valid = 1'b0; #1;
      chk("t4_flushed", 32'(if_valid), 32'd0);
      chk("t4_addr", imem_req_addr, 32'h200);
      chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
      tick();
      chk("t4_d6_if_valid", 32'(if_valid), 32'd0);
      tick();
      chk("t4_d7_if_valid", 32'(if_valid), 32'd0);
      tick();
      chk("t4_first_valid", 32'(if_valid), 32'd1);
      chk("t4_first_pc", if_pc, 32'h200);
      chk("t4_first_instr", if_instr, 32'hDEAD_0200);

      // Address wrap after redirect near the top of the address space
      rst = 1'b0; lat = 1; if_ready = 1'b1; tick(); tick();
      rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; #1;
      chk("t5_redir_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
      redirect_valid = 1'b0; #1;
      chk("t5_addr0", imem_req_addr, 32'hFFFF_FFF8);
      tick();
      chk("t5_addr1", imem_req_addr, 32'hFFFF_FFFC);
      tick();
      chk("t5_addr2", imem_req_addr, 32'h0000_0000);
      chk("t5_pc0", if_pc, 32'hFFFF_FFF8);
      chk("t5_instr0", if_instr, 32'h2152_FFF8);
      tick();
      chk("t5_pc1", if_pc, 32'hFFFF_FFFC);
      tick();
      chk("t5_pc2", if_pc, 32'h0000_0000);
      chk("t5_instr2", if_instr, 32'hDEAD_0000);

      // Reset mid-burst with FIFO and memory both occupied
      rst = 1'b0; lat = 2; if_ready = 1'b0; tick(); tick();
      rst = 1'b1;
      repeat (4) tick();
      chk("t6_pre_if_valid", 32'(if_valid), 32'd1);
      rst = 1'b0; #1;
      chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
      chk("t6_if_valid", 32'(if_valid), 32'd0);
      chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
      chk("t6_if_pc", if_pc, 32'h0);
      chk("t6_if_instr", if_instr, 32'h0);
      rst = 1'b1; #1;
      chk("t6_restart_valid", 32'(imem_req_valid), 32'd1);
      chk("t6_restart_addr", imem_req_addr, 32'h0);
      tick();
      chk("t6_next_addr", imem_req_addr, 32'h4);

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
